// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU among NREQ requesters.
// Grants one requester, drives its operands to the ALU, captures the result and returns it over valid/ready.
module alu_share_ctrl #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic [NREQ*3-1:0] op_in,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_f,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      result,
  output logic [IDW-1:0]    res_id,
  output logic              div_zero,
  output logic              busy
);

  localparam logic [2:0] OP_DIV = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] winner;

  logic           any_req_c;
  logic           hi_found_c;
  logic [IDW-1:0] hi_idx_c;
  logic [IDW-1:0] lo_idx_c;
  logic [IDW-1:0] win_idx_c;
  logic [W-1:0]   win_a_c;
  logic [W-1:0]   win_b_c;
  logic [2:0]     win_op_c;
  logic [IDW-1:0] rr_next_c;
  logic           div_zero_c;

  // Round-robin pick: lowest set bit at or above rr, else lowest set bit overall (wrap).
  always_comb begin
    any_req_c  = 1'b0;
    hi_found_c = 1'b0;
    hi_idx_c   = '0;
    lo_idx_c   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req_c = 1'b1;
        lo_idx_c  = IDW'(i);
        if (i >= int'(rr)) begin
          hi_found_c = 1'b1;
          hi_idx_c   = IDW'(i);
        end
      end
    end
    win_idx_c = hi_found_c ? hi_idx_c : lo_idx_c;
  end

  // Winner's operand slices.
  always_comb begin
    win_a_c  = '0;
    win_b_c  = '0;
    win_op_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (int'(win_idx_c) == i) begin
        win_a_c  = a_in[i*W +: W];
        win_b_c  = b_in[i*W +: W];
        win_op_c = op_in[i*3 +: 3];
      end
    end
  end

  always_comb begin
    rr_next_c  = (int'(winner) == int'(NREQ) - 1) ? '0 : winner + IDW'(1);
    div_zero_c = (alu_op == OP_DIV) && (alu_b == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      winner    <= '0;
      gnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      result    <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req_c) begin
            alu_a  <= win_a_c;
            alu_b  <= win_b_c;
            alu_op <= win_op_c;
            gnt    <= NREQ'(1) << win_idx_c;
            winner <= win_idx_c;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // A divide by zero returns all ones regardless of what the ALU produced.
          result    <= div_zero_c ? '1 : alu_f;
          div_zero  <= div_zero_c;
          res_id    <= winner;
          res_valid <= 1'b1;
          rr        <= rr_next_c;
          gnt       <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          gnt       <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: hosts the shared ALU, runs directed vectors, reset corners and random traffic.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_in, b_in;
  logic [11:0] op_in;
  logic [3:0]  gnt;
  logic [3:0]  alu_a, alu_b, alu_f;
  logic [2:0]  alu_op;
  logic        res_valid, res_ready;
  logic [3:0]  result;
  logic [1:0]  res_id;
  logic        div_zero, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m    = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.W(4), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .res_id(res_id), .div_zero(div_zero), .busy(busy)
  );

  // The shared ALU itself; divide by zero yields 0 here so the forced 4'hF is observable.
  always_comb begin
    case (alu_op)
      3'd0: alu_f = alu_a + alu_b;
      3'd1: alu_f = alu_a - alu_b;
      3'd2: alu_f = alu_a * alu_b;
      3'd3: alu_f = (alu_b == 4'd0) ? 4'd0 : alu_a / alu_b;
      3'd4: alu_f = alu_a & alu_b;
      3'd5: alu_f = alu_a | alu_b;
      3'd6: alu_f = alu_a ^ alu_b;
      default: alu_f = ~alu_a;
    endcase
  end

  typedef struct {
    logic [3:0] mask;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    int         hold;
    int         eid;
    int         eres;
    int         edz;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] m, input int rr);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (rr + k) % 4;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return (a * b) % 16;
      3: return (b == 0) ? 15 : a / b;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return 15 - a;
    endcase
  endfunction

  // One full transaction starting at a negedge in IDLE; ends at a negedge back in IDLE with req cleared.
  task automatic run_txn(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b,
                         input logic [11:0] op, input int hold,
                         input int eid, input int eres, input int edz);
    logic [3:0] ea, eb;
    logic [2:0] eop;
    ea  = a[eid*4 +: 4];
    eb  = b[eid*4 +: 4];
    eop = op[eid*3 +: 3];
    req = mask; a_in = a; b_in = b; op_in = op;
    res_ready = (hold == 0);
    @(negedge clk);
    chk("gnt", int'(gnt), 1 << eid);
    chk("alu_a", int'(alu_a), int'(ea));
    chk("alu_b", int'(alu_b), int'(eb));
    chk("alu_op", int'(alu_op), int'(eop));
    chk("busy_exec", int'(busy), 1);
    chk("valid_exec", int'(res_valid), 0);
    // Granted requester moves on; others keep requesting, which must be ignored.
    req   = mask & ~(4'(1) << eid);
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
    op_in = 12'($urandom);
    @(negedge clk);
    chk("valid_resp", int'(res_valid), 1);
    chk("result", int'(result), eres);
    chk("res_id", int'(res_id), eid);
    chk("div_zero", int'(div_zero), edz);
    chk("gnt_resp", int'(gnt), 0);
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      chk("valid_hold", int'(res_valid), 1);
      chk("result_hold", int'(result), eres);
      chk("res_id_hold", int'(res_id), eid);
      chk("gnt_hold", int'(gnt), 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("valid_done", int'(res_valid), 0);
    chk("busy_done", int'(busy), 0);
    req = '0;
    rr_m = (eid + 1) % 4;
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 4'd7,  4'd9,  3'd2, 0, 3, 15, 0};
    vecs[1]  = '{4'b1111, 4'd2,  4'd5,  3'd1, 0, 0, 13, 0};
    vecs[2]  = '{4'b1111, 4'd2,  4'd5,  3'd1, 0, 1, 13, 0};
    vecs[3]  = '{4'b1111, 4'd2,  4'd5,  3'd1, 0, 2, 13, 0};
    vecs[4]  = '{4'b1111, 4'd2,  4'd5,  3'd1, 0, 3, 13, 0};
    vecs[5]  = '{4'b1111, 4'd2,  4'd5,  3'd1, 0, 0, 13, 0};
    vecs[6]  = '{4'b0001, 4'd3,  4'd10, 3'd0, 0, 0, 13, 0};
    vecs[7]  = '{4'b0100, 4'd8,  4'd0,  3'd3, 0, 2, 15, 1};
    vecs[8]  = '{4'b1111, 4'd12, 4'd10, 3'd4, 5, 3, 8,  0};
    vecs[9]  = '{4'b0110, 4'd12, 4'd3,  3'd5, 1, 1, 15, 0};
    vecs[10] = '{4'b0011, 4'd12, 4'd10, 3'd6, 0, 0, 6,  0};
    vecs[11] = '{4'b0100, 4'd5,  4'd0,  3'd7, 2, 2, 10, 0};
    vecs[12] = '{4'b1001, 4'd13, 4'd4,  3'd3, 0, 3, 3,  0};
    vecs[13] = '{4'b0001, 4'd4,  4'd4,  3'd2, 0, 0, 0,  0};
    vecs[14] = '{4'b0010, 4'd9,  4'd3,  3'd3, 0, 1, 3,  0};

    // Reset with all requests high: nothing may be granted.
    rst = 1'b1; req = 4'hF; a_in = '0; b_in = '0; op_in = '0; res_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_alu", int'({alu_a, alu_b, alu_op}), 0);
      chk("rst_out", int'({result, res_id, div_zero}), 0);
    end
    rst = 1'b0;
    run_txn(4'hF, {4{4'd3}}, {4{4'd10}}, 12'h0, 0, 0, 13, 0);

    foreach (vecs[i])
      run_txn(vecs[i].mask, {4{vecs[i].a}}, {4{vecs[i].b}}, {4{vecs[i].op}},
              vecs[i].hold, vecs[i].eid, vecs[i].eres, vecs[i].edz);

    // Reset during EXEC of a grant to requester 1 (rr was 2).
    req = 4'b0010; a_in = {4{4'd1}}; b_in = {4{4'd1}}; op_in = '0; res_ready = 1'b1;
    @(negedge clk);
    chk("exec_rst_gnt", int'(gnt), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("exec_rst_valid", int'(res_valid), 0);
    chk("exec_rst_busy", int'(busy), 0);
    chk("exec_rst_alu", int'({alu_a, alu_b, alu_op, gnt}), 0);
    rst = 1'b0; req = '0; rr_m = 0;
    @(negedge clk);
    chk("exec_rst_no_result", int'(res_valid), 0);
    // From rr = 0 requester 1 wins over 3; a stale rr of 2 would pick 3.
    run_txn(4'b1010, {4{4'd6}}, {4{4'd7}}, 12'h0, 0, 1, 13, 0);

    // Reset while a result waits in RESP.
    req = 4'b0001; a_in = {4{4'd8}}; b_in = '0; op_in = {4{3'd3}}; res_ready = 1'b0;
    @(negedge clk);
    chk("resp_rst_gnt", int'(gnt), 1);
    req = '0;
    @(negedge clk);
    chk("resp_rst_valid_pre", int'(res_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("resp_rst_valid", int'(res_valid), 0);
    chk("resp_rst_out", int'({result, res_id, div_zero, busy}), 0);
    rst = 1'b0; rr_m = 0;

    // Random traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      logic [3:0]  m;
      logic [15:0] ra, rb;
      logic [11:0] rop;
      int          w, er, edz;
      m   = 4'($urandom_range(1, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 12'($urandom);
      for (int l = 0; l < 4; l++)
        if ($urandom_range(0, 3) == 0) rb[l*4 +: 4] = 4'd0;
      w   = ref_pick(m, rr_m);
      er  = ref_alu(int'(ra[w*4 +: 4]), int'(rb[w*4 +: 4]), int'(rop[w*3 +: 3]));
      edz = (rop[w*3 +: 3] == 3'd3 && rb[w*4 +: 4] == 4'd0) ? 1 : 0;
      run_txn(m, ra, rb, rop, int'($urandom_range(0, 3)), w, er, edz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
